ex_stage_reg: RTL and testbench

- Execute-stage consumer of the ID/EX pipeline register. Takes the registered control bits, operands, immediate and instruction word from ID/EX.
- Resolves operand forwarding, decodes ALU control, computes the 64-bit result and registers everything into the EX/MEM pipeline register.
- Sits between the ID/EX register and the MEM stage of the 5-stage RV64 pipeline.

---
 rtl/ex_stage_reg.sv | 168 ++++++++++++++++
 tb/tb_ex_stage_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_reg.sv
// Execute stage: forwards operands, decodes and runs the ALU, and registers the results into EX/MEM.
// Optional macro FWD_EN enables EX/MEM and MEM/WB operand forwarding; without it, operands come straight from ID/EX.
module ex_stage_reg #(
  parameter int INST_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_memRead,
  input  logic              i_memToReg,
  input  logic [1:0]        i_aluOp,
  input  logic              i_memWrite,
  input  logic              i_aluSrc,
  input  logic              i_regWrite,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_flush,
  input  logic              i_wb_regWrite,
  input  logic [4:0]        i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_memRead,
  output logic              o_memToReg,
  output logic              o_memWrite,
  output logic              o_regWrite,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_store_data,
  output logic [4:0]        o_rd,
  output logic              o_zero
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND, ALU_ZERO
  } alu_op_t;

  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic       f7b;
  logic [6:0] opcode;

  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];
  assign rd     = i_inst[11:7];
  assign funct3 = i_inst[14:12];
  assign f7b    = i_inst[30];
  assign opcode = i_inst[6:0];

  logic [DATA_W-1:0] fwd_a, fwd_b, opb;

`ifdef FWD_EN
  // A load's EX/MEM value is an address, not data, so it is never a forward source.
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic mem_src_ok, wb_src_ok;

  assign mem_src_ok = o_regWrite && !o_memRead && (o_rd != 5'd0);
  assign wb_src_ok  = i_wb_regWrite && (i_wb_rd != 5'd0);
  assign mem_hit_a  = mem_src_ok && (o_rd == rs1);
  assign mem_hit_b  = mem_src_ok && (o_rd == rs2);
  assign wb_hit_a   = wb_src_ok && (i_wb_rd == rs1);
  assign wb_hit_b   = wb_src_ok && (i_wb_rd == rs2);

  always_comb begin
    fwd_a = i_rs1_data;
    if (mem_hit_a)     fwd_a = o_alu_result;
    else if (wb_hit_a) fwd_a = i_wb_data;
  end

  always_comb begin
    fwd_b = i_rs2_data;
    if (mem_hit_b)     fwd_b = o_alu_result;
    else if (wb_hit_b) fwd_b = i_wb_data;
  end

  logic unused_bits;
  assign unused_bits = ^{i_inst};
`else
  assign fwd_a = i_rs1_data;
  assign fwd_b = i_rs2_data;

  logic unused_bits;
  assign unused_bits = ^{i_inst, i_wb_regWrite, i_wb_rd, i_wb_data};
`endif

  assign opb = i_aluSrc ? i_imm : fwd_b;

  alu_op_t alu_op;

  always_comb begin
    alu_op = ALU_ZERO;
    case (i_aluOp)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000: alu_op = (opcode == OPC_RTYPE && f7b) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = f7b ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_ZERO;
    endcase
  end

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] alu_res;

  assign shamt = opb[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = fwd_a + opb;
      ALU_SUB:  alu_res = fwd_a - opb;
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(opb))};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (fwd_a < opb)};
      ALU_XOR:  alu_res = fwd_a ^ opb;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
      ALU_OR:   alu_res = fwd_a | opb;
      ALU_AND:  alu_res = fwd_a & opb;
      default:  alu_res = '0;
    endcase
  end

  // Flush clears data as well as control so a bubble is fully deterministic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_memRead    <= 1'b0;
      o_memToReg   <= 1'b0;
      o_memWrite   <= 1'b0;
      o_regWrite   <= 1'b0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_rd         <= 5'd0;
      o_zero       <= 1'b0;
    end else if (i_flush) begin
      o_memRead    <= 1'b0;
      o_memToReg   <= 1'b0;
      o_memWrite   <= 1'b0;
      o_regWrite   <= 1'b0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_rd         <= 5'd0;
      o_zero       <= 1'b0;
    end else begin
      o_memRead    <= i_memRead;
      o_memToReg   <= i_memToReg;
      o_memWrite   <= i_memWrite;
      o_regWrite   <= i_regWrite;
      o_alu_result <= alu_res;
      o_store_data <= fwd_b;
      o_rd         <= rd;
      o_zero       <= (alu_res == '0);
    end
  end

endmodule

// File: tb/tb_ex_stage_reg.sv
// Directed table-driven bench for ex_stage_reg, plus hand-written reset sequences.
module tb_ex_stage_reg;

  localparam int DW = 64;
  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read, mem_to_reg, mem_write, alu_src, reg_write, flush;
  logic [1:0]    alu_op;
  logic [DW-1:0] rs1_data, rs2_data, imm, wb_data;
  logic [31:0]   inst;
  logic          wb_reg_write;
  logic [4:0]    wb_rd;
  logic          q_mem_read, q_mem_to_reg, q_mem_write, q_reg_write, q_zero;
  logic [DW-1:0] q_alu_result, q_store_data;
  logic [4:0]    q_rd;

  int n_cmp = 0;
  int n_bad = 0;

  ex_stage_reg dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_memRead(mem_read), .i_memToReg(mem_to_reg), .i_aluOp(alu_op),
    .i_memWrite(mem_write), .i_aluSrc(alu_src), .i_regWrite(reg_write),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm), .i_inst(inst),
    .i_flush(flush), .i_wb_regWrite(wb_reg_write), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_memRead(q_mem_read), .o_memToReg(q_mem_to_reg), .o_memWrite(q_mem_write),
    .o_regWrite(q_reg_write), .o_alu_result(q_alu_result), .o_store_data(q_store_data),
    .o_rd(q_rd), .o_zero(q_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]    aop;
    logic          mr, m2r, mw, asrc, rw, fl, wbw;
    logic [DW-1:0] a, b, im, wbd;
    logic [31:0]   ins;
    logic [4:0]    wbrd;
    logic [DW-1:0] e_res, e_st;
    logic [4:0]    e_rd;
    logic          e_zero;
    logic [3:0]    e_ctrl;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic vec_t mk(input logic mr, input logic m2r, input logic [1:0] aop,
                              input logic mw, input logic asrc, input logic rw,
                              input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] im, input logic [31:0] ins,
                              input logic fl, input logic wbw, input logic [4:0] wbrd,
                              input logic [DW-1:0] wbd, input logic [DW-1:0] e_res,
                              input logic [DW-1:0] e_st, input logic [4:0] e_rd,
                              input logic e_zero, input logic [3:0] e_ctrl);
    vec_t v;
    v.mr = mr; v.m2r = m2r; v.aop = aop; v.mw = mw; v.asrc = asrc; v.rw = rw;
    v.a = a; v.b = b; v.im = im; v.ins = ins; v.fl = fl;
    v.wbw = wbw; v.wbrd = wbrd; v.wbd = wbd;
    v.e_res = e_res; v.e_st = e_st; v.e_rd = e_rd; v.e_zero = e_zero; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] res, input logic [DW-1:0] st,
                         input logic [4:0] rd, input logic zero, input logic [3:0] ctrl);
    chk({tag, ".alu_result"}, q_alu_result, res);
    chk({tag, ".store_data"}, q_store_data, st);
    chk({tag, ".rd"}, {59'd0, q_rd}, {59'd0, rd});
    chk({tag, ".zero"}, {63'd0, q_zero}, {63'd0, zero});
    chk({tag, ".ctrl"}, {60'd0, q_mem_read, q_mem_to_reg, q_mem_write, q_reg_write}, {60'd0, ctrl});
  endtask

  task automatic drive(input vec_t v);
    mem_read = v.mr; mem_to_reg = v.m2r; alu_op = v.aop; mem_write = v.mw;
    alu_src = v.asrc; reg_write = v.rw; rs1_data = v.a; rs2_data = v.b;
    imm = v.im; inst = v.ins; flush = v.fl;
    wb_reg_write = v.wbw; wb_rd = v.wbrd; wb_data = v.wbd;
  endtask

  initial begin
    logic [DW-1:0] neg1, msb;
    vec_t v;
    neg1 = '1;
    msb  = 64'h8000_0000_0000_0000;

    // mr m2r aop mw asrc rw | a b imm | inst | fl wbw wbrd wbd | res st rd zero ctrl{mr,m2r,mw,rw}
    vecs.push_back(mk(0,0,2'b00,0,1,1, 64'h100,0,8, enc(0,3,2,0,1,I), 0,0,0,0, 64'h108,0,1,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 5,7,0, enc(7'h20,7,5,0,8,R), 0,0,0,0, 64'hFFFF_FFFF_FFFF_FFFE,7,8,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 8,8,0, enc(0,3,4,0,5,R), 0,0,0,0, 64'h10,8,5,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 0,0,0, enc(0,5,5,0,6,R), 0,0,0,0,
                      FWD ? 64'h20 : 64'h0, FWD ? 64'h10 : 64'h0, 6, !FWD, 4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 8,8,0, enc(0,3,4,0,5,R), 0,0,0,0, 64'h10,8,5,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 0,0,0, enc(0,0,5,0,7,R), 0,1,5,64'h99,
                      FWD ? 64'h10 : 64'h0, 0, 7, !FWD, 4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 1,1,0, enc(0,9,9,0,10,R), 0,1,9,64'h99,
                      FWD ? 64'h132 : 64'h2, FWD ? 64'h99 : 64'h1, 10, 0, 4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 64'h55,1,0, enc(0,3,4,0,0,R), 0,1,0,64'h77, 64'h56,1,0,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 3,4,0, enc(0,0,0,0,11,R), 0,1,0,64'h77, 7,4,11,0,4'b0001));
    vecs.push_back(mk(1,1,2'b00,0,1,1, 64'h1000,0,64'h10, enc(0,0,2,3,12,LD), 0,0,0,0, 64'h1010,0,12,0,4'b1101));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 2,3,0, enc(0,12,12,0,13,R), 0,0,0,0, 5,3,13,0,4'b0001));
    vecs.push_back(mk(0,0,2'b00,1,1,0, 64'h2000,5,8, enc(0,13,2,3,8,ST), 1,0,0,0, 0,0,0,0,4'b0000));
    vecs.push_back(mk(0,0,2'b10,0,0,1, neg1,1,0, enc(0,2,1,2,14,R), 0,0,0,0, 1,1,14,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, neg1,1,0, enc(0,2,1,3,15,R), 0,0,0,0, 0,1,15,1,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, msb,4,0, enc(7'h20,2,1,5,16,R), 0,0,0,0, 64'hF800_0000_0000_0000,4,16,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, msb,4,0, enc(0,2,1,5,17,R), 0,0,0,0, 64'h0800_0000_0000_0000,4,17,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,1,1, 3,9,64'h41, enc(0,2,1,1,18,I), 0,0,0,0, 6,9,18,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 64'hF0F0,64'hFF00,0, enc(0,2,1,4,19,R), 0,0,0,0, 64'h0FF0,64'hFF00,19,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 64'hF0F0,64'hFF00,0, enc(0,2,1,6,20,R), 0,0,0,0, 64'hFFF0,64'hFF00,20,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,0,1, 64'hF0F0,64'hFF00,0, enc(0,2,1,7,21,R), 0,0,0,0, 64'hF000,64'hFF00,21,0,4'b0001));
    vecs.push_back(mk(0,0,2'b11,0,0,1, 5,3,0, enc(0,2,1,0,22,R), 0,0,0,0, 0,3,22,1,4'b0001));
    vecs.push_back(mk(0,0,2'b01,0,0,1, 10,3,0, enc(0,2,1,0,23,R), 0,0,0,0, 7,3,23,0,4'b0001));
    vecs.push_back(mk(0,0,2'b10,0,1,1, 5,0,3, enc(7'h20,2,1,0,24,I), 0,0,0,0, 8,0,24,0,4'b0001));

    drive(vecs[0]);
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", k), vecs[k].e_res, vecs[k].e_st, vecs[k].e_rd,
              vecs[k].e_zero, vecs[k].e_ctrl);
    end

    // Asynchronous reset between edges while EX/MEM holds a valid instruction.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 4'b0000);

    // First edge after release loads whatever ID/EX presents.
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(0,0,2'b00,0,1,1, 64'h100,0,64'h20, enc(0,3,2,0,3,I), 0,0,0,0, 64'h120,0,3,0,4'b0001);
    drive(v);
    @(posedge clk);
    #1;
    chk_all("post_rst", v.e_res, v.e_st, v.e_rd, v.e_zero, v.e_ctrl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
